ped_signal_ctrl: RTL
====================

Name: ped_signal_ctrl

Overview:
- Downstream consumer of the intersection light controller's per-approach traffic_light codes (north/south/east/west; GREEN=0, YELLOW=1, RED=2, LEFT=3).
- Drives the pedestrian WALK / DON'T WALK heads for the two crosswalks: NS crosswalk runs parallel to N/S traffic, EW crosswalk parallel to E/W traffic.
- Latches push-button requests, grants a timed WALK then flashing-clearance phase at the start of the parallel through-green, and flags inconsistent light inputs as a safety fault.

Parameters:
- WALK_CYCLES, 20, exact number of cycles WALK is lit per grant.
- FLASH_CYCLES, 15, exact number of cycles of flashing DON'T WALK clearance after WALK.
- FLASH_HALF, 2, cycles per on/off half-period of the flashing DON'T WALK.
- CNT_W, 8, width of the phase counter and the countdown outputs; must hold max(WALK_CYCLES, FLASH_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- north  input  2  traffic_light code, north approach.
- south  input  2  traffic_light code, south approach.
- east  input  2  traffic_light code, east approach.
- west  input  2  traffic_light code, west approach.
- ns_req  input  1  NS crosswalk button, level or pulse.
- ew_req  input  1  EW crosswalk button.
- ns_ack  output  1  one-cycle pulse when an NS request is served.
- ew_ack  output  1  one-cycle pulse when an EW request is served.
- ns_walk  output  1  NS WALK lamp.
- ew_walk  output  1  EW WALK lamp.
- ns_dont_walk  output  1  NS DON'T WALK lamp, steady or flashing.
- ew_dont_walk  output  1  EW DON'T WALK lamp.
- ns_countdown  output  CNT_W  NS clearance cycles remaining.
- ew_countdown  output  CNT_W  EW clearance cycles remaining.
- fault  output  1  sticky input-consistency fault.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high. All outputs are registered.
- Reset values: walk=0, dont_walk=1, ack=0, countdown=0, fault=0, request latches=0, both axes in DONT_WALK, previous-input registers=RED.
- Two identical per-axis FSMs. NS is keyed on north, EW on east. States: DONT_WALK, WALK, FLASH.
- Green-entry event: the axis input is GREEN and the registered previous value is not GREEN.
- DONT_WALK -> WALK:
  - Taken on a green-entry edge when the latch or the same-cycle req is 1.
  - At that edge: walk=1, dont_walk=0, ack=1 for exactly one cycle, latch cleared.
  - Latency: one edge after the input is sampled.
- Green entry with no pending request: remain in DONT_WALK. No grant occurs later in that same green.
- WALK -> FLASH after exactly WALK_CYCLES cycles of walk=1.
- FLASH behaviour:
  - walk=0; dont_walk starts lit and toggles every FLASH_HALF cycles.
  - countdown loads FLASH_CYCLES on entry and decrements by 1 each cycle.
- FLASH -> DONT_WALK after exactly FLASH_CYCLES cycles: dont_walk=1 steady, countdown=0.
- Early abort: if the axis input leaves GREEN during WALK or FLASH, go to DONT_WALK at the next edge (dont_walk=1, walk=0, countdown=0).
- countdown is 0 in every state except FLASH.
- Request latch:
  - Set on any cycle req=1.
  - req during WALK or FLASH of the same axis stays latched for the next green and produces no ack now.
  - Held through reset release only if asserted after reset.
- Fault detection:
  - Condition: north!=south, or east!=west, or (north!=RED and east!=RED) on the same cycle.
  - Effect: fault=1 from the next edge and stays set until rst.
  - While fault=1: both axes are forced to DONT_WALK (dont_walk=1 steady, walk=0, countdown=0, ack=0). Latches keep accumulating but no grants occur.
- rst asserted mid-phase: all outputs immediately return to their reset values.

Optional Feature:
- Macro: PED_COUNTDOWN_EN.
- Defined: countdown outputs behave as above.
- Undefined: ns_countdown and ew_countdown are tied to 0 and the FLASH phase timer is internal only. FLASH timing and every other output are unchanged.

Test Plan:
- Pulse ns_req, then north=south=GREEN with east=west=RED for 40 cycles -> ns_ack pulses once at the entry edge; ns_walk high 20 cycles; then 15 cycles of ns_dont_walk toggling every 2 cycles (starting lit) with ns_countdown 15..1; then steady DON'T WALK with countdown 0.
- Same green with no request -> ns_walk stays 0, ns_ack stays 0, ns_dont_walk steady 1 throughout.
- Request granted, then north/south go YELLOW after 10 walk cycles -> next edge ns_walk=0, ns_dont_walk=1, ns_countdown=0.
- ew_req asserted on the exact edge east first reads GREEN -> grant that edge (ew_ack=1). A second ew_req during WALK -> no ack now; ew_ack=1 at the next EW green entry.
- north=GREEN, east=LEFT on one cycle -> fault=1 next edge; all walk=0 and dont_walk=1 steady; a later valid green with a pending request produces no grant until rst.
- Assert rst mid-WALK -> walk=0, dont_walk=1, ack=0, countdown=0, fault=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK / DON'T WALK controller for the NS and EW crosswalks, keyed on the north and east lights.
// Optional PED_COUNTDOWN_EN drives the clearance countdown outputs; otherwise they are tied to 0.
module ped_signal_ctrl #(
  parameter int WALK_CYCLES  = 20,
  parameter int FLASH_CYCLES = 15,
  parameter int FLASH_HALF   = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       north,
  input  logic [1:0]       south,
  input  logic [1:0]       east,
  input  logic [1:0]       west,
  input  logic             ns_req,
  input  logic             ew_req,
  output logic             ns_ack,
  output logic             ew_ack,
  output logic             ns_walk,
  output logic             ew_walk,
  output logic             ns_dont_walk,
  output logic             ew_dont_walk,
  output logic [CNT_W-1:0] ns_countdown,
  output logic [CNT_W-1:0] ew_countdown,
  output logic             fault
);

  typedef enum logic [1:0] {DONT_WALK, WALK, FLASH} state_e;

  localparam logic [1:0]       GREEN      = 2'd0;
  localparam logic [1:0]       RED        = 2'd2;
  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(FLASH_HALF - 1);

  // Index 0 is the NS axis (keyed on north), index 1 the EW axis (keyed on east).
  logic [1:0] light [2];
  logic [1:0] req;
  assign light[0] = north;
  assign light[1] = east;
  assign req      = {ew_req, ns_req};

  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [CNT_W-1:0] half_q  [2];
  logic [CNT_W-1:0] half_d  [2];
  logic [1:0]       prev_q  [2];
  logic [1:0]       prev_d  [2];
  logic [1:0]       latch_q, latch_d;
  logic [1:0]       walk_q, walk_d;
  logic [1:0]       dont_walk_q, dont_walk_d;
  logic [1:0]       ack_q, ack_d;
  logic             fault_q, fault_d;
  logic             fault_cond;
  logic [1:0]       green, entry;

  assign fault_cond = (north != south) || (east != west) || ((north != RED) && (east != RED));

  always_comb begin
    fault_d     = fault_q | fault_cond;
    latch_d     = latch_q | req;
    walk_d      = walk_q;
    dont_walk_d = dont_walk_q;
    ack_d       = 2'b00;
    green       = 2'b00;
    entry       = 2'b00;
    for (int a = 0; a < 2; a++) begin
      state_d[a] = state_q[a];
      cnt_d[a]   = cnt_q[a];
      half_d[a]  = half_q[a];
      prev_d[a]  = light[a];
      green[a]   = (light[a] == GREEN);
      entry[a]   = green[a] && (prev_q[a] != GREEN);

      // A fault raised this cycle already suppresses grants at this edge.
      if (fault_d) begin
        state_d[a]     = DONT_WALK;
        walk_d[a]      = 1'b0;
        dont_walk_d[a] = 1'b1;
        cnt_d[a]       = '0;
        half_d[a]      = '0;
      end else begin
        case (state_q[a])
          DONT_WALK: begin
            walk_d[a]      = 1'b0;
            dont_walk_d[a] = 1'b1;
            if (entry[a] && (latch_q[a] || req[a])) begin
              state_d[a]     = WALK;
              walk_d[a]      = 1'b1;
              dont_walk_d[a] = 1'b0;
              ack_d[a]       = 1'b1;
              latch_d[a]     = 1'b0;
              cnt_d[a]       = WALK_LOAD;
            end
          end
          WALK: begin
            if (!green[a]) begin
              state_d[a]     = DONT_WALK;
              walk_d[a]      = 1'b0;
              dont_walk_d[a] = 1'b1;
            end else if (cnt_q[a] == '0) begin
              state_d[a]     = FLASH;
              walk_d[a]      = 1'b0;
              dont_walk_d[a] = 1'b1;
              cnt_d[a]       = FLASH_LOAD;
              half_d[a]      = '0;
            end else begin
              cnt_d[a] = cnt_q[a] - CNT_W'(1);
            end
          end
          FLASH: begin
            if (!green[a] || (cnt_q[a] == '0)) begin
              state_d[a]     = DONT_WALK;
              walk_d[a]      = 1'b0;
              dont_walk_d[a] = 1'b1;
            end else begin
              cnt_d[a] = cnt_q[a] - CNT_W'(1);
              if (half_q[a] == HALF_LAST) begin
                dont_walk_d[a] = ~dont_walk_q[a];
                half_d[a]      = '0;
              end else begin
                half_d[a] = half_q[a] + CNT_W'(1);
              end
            end
          end
          default: begin
            state_d[a]     = DONT_WALK;
            walk_d[a]      = 1'b0;
            dont_walk_d[a] = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < 2; a++) begin
        state_q[a] <= DONT_WALK;
        cnt_q[a]   <= '0;
        half_q[a]  <= '0;
        prev_q[a]  <= RED;
      end
      latch_q     <= 2'b00;
      walk_q      <= 2'b00;
      dont_walk_q <= 2'b11;
      ack_q       <= 2'b00;
      fault_q     <= 1'b0;
    end else begin
      for (int a = 0; a < 2; a++) begin
        state_q[a] <= state_d[a];
        cnt_q[a]   <= cnt_d[a];
        half_q[a]  <= half_d[a];
        prev_q[a]  <= prev_d[a];
      end
      latch_q     <= latch_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      ack_q       <= ack_d;
      fault_q     <= fault_d;
    end
  end

`ifdef PED_COUNTDOWN_EN
  // In FLASH the phase counter holds remaining-minus-one, so the display is one above it.
  logic [CNT_W-1:0] countdown_q [2];
  logic [CNT_W-1:0] countdown_d [2];

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      countdown_d[a] = '0;
      if (state_d[a] == FLASH) countdown_d[a] = cnt_d[a] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countdown_q[0] <= '0;
      countdown_q[1] <= '0;
    end else begin
      countdown_q[0] <= countdown_d[0];
      countdown_q[1] <= countdown_d[1];
    end
  end

  assign ns_countdown = countdown_q[0];
  assign ew_countdown = countdown_q[1];
`else
  assign ns_countdown = '0;
  assign ew_countdown = '0;
`endif

  assign ns_ack       = ack_q[0];
  assign ew_ack       = ack_q[1];
  assign ns_walk      = walk_q[0];
  assign ew_walk      = walk_q[1];
  assign ns_dont_walk = dont_walk_q[0];
  assign ew_dont_walk = dont_walk_q[1];
  assign fault        = fault_q;

endmodule
